// File: rtl/rtc_edit_sequencer.sv
// rtc_edit_sequencer: turns front-panel buttons into per-field RTC edit pulses, load strobes and a commit write request
module rtc_edit_sequencer #(
  parameter int REPEAT_START = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int TIMEOUT      = 500_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_edit,
  input  logic       i_btn_next,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_rd_done,
  input  logic       i_wr_ack,
  output logic       o_modify,
  output logic [2:0] o_up_sel,
  output logic [2:0] o_down_sel,
  output logic       o_load,
  output logic       o_wr_req,
  output logic [1:0] o_sel
);
  localparam int RW = $clog2((REPEAT_START > REPEAT_RATE ? REPEAT_START : REPEAT_RATE) + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;
  state_t r_state, w_next;
  logic [3:0] r_btn_q, w_btn, w_edge;
  logic r_armed;
  logic [RW-1:0] r_rep, w_rep;
  logic [TW-1:0] r_to, w_to;
  logic [1:0] w_sel;
  logic [2:0] w_onehot;
  logic w_up_only, w_dn_only, w_rep_hit, w_to_hit, w_up, w_dn;
  assign w_btn = {i_btn_down, i_btn_up, i_btn_next, i_btn_edit};
  assign w_edge = r_armed ? (w_btn & ~r_btn_q) : 4'd0;
  assign w_up_only = i_btn_up & ~i_btn_down;
  assign w_dn_only = i_btn_down & ~i_btn_up;
  assign w_rep_hit = r_rep == RW'(REPEAT_START);
  assign w_to_hit = r_to == TW'(TIMEOUT - 1);
  assign w_onehot = 3'b001 << o_sel;
  always_ff @(posedge i_clk)
    r_state <= i_reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_sel = o_sel;
    w_up = 1'b0;
    w_dn = 1'b0;
    w_rep = '0;
    w_to = '0;
    if (r_state == IDLE) begin
      if (w_edge[0]) begin
        w_next = EDIT;
        w_sel = 2'd0;
      end
    end else if (r_state == EDIT) begin
      w_rep = ((w_up_only && w_edge[2]) || (w_dn_only && w_edge[3])) ? RW'(1)
            : (r_rep == '0 || !(w_up_only || w_dn_only)) ? '0
            : w_rep_hit ? RW'(REPEAT_START - REPEAT_RATE + 1) : r_rep + 1'b1;
      if (w_edge[0])
        w_next = COMMIT;
      else if (w_to_hit)
        w_next = IDLE;
      else if (w_edge[1])
        w_sel = (o_sel == 2'd2) ? 2'd0 : o_sel + 2'd1;
      else begin
        w_up = w_up_only && (w_edge[2] || w_rep_hit);
        w_dn = w_dn_only && (w_edge[3] || w_rep_hit);
      end
      w_to = (|w_edge || w_up || w_dn) ? '0 : r_to + 1'b1;
    end else if (i_wr_ack)
      w_next = IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_btn_q <= 4'd0;
      r_armed <= 1'b0;
      r_rep <= '0;
      r_to <= '0;
      o_sel <= 2'd0;
      o_modify <= 1'b0;
      o_wr_req <= 1'b0;
      o_load <= 1'b0;
      o_up_sel <= 3'd0;
      o_down_sel <= 3'd0;
    end else begin
      r_btn_q <= w_btn;
      r_armed <= 1'b1;
      r_rep <= w_rep;
      r_to <= w_to;
      o_sel <= w_sel;
      o_modify <= w_next != IDLE;
      o_wr_req <= w_next == COMMIT;
      o_load <= (r_state == IDLE) && i_rd_done;
      o_up_sel <= w_up ? w_onehot : 3'd0;
      o_down_sel <= w_dn ? w_onehot : 3'd0;
    end
endmodule

// File: tb/tb_rtc_edit_sequencer.sv
// tb_rtc_edit_sequencer: directed and random button traffic scored against a cycle reference model
module tb_rtc_edit_sequencer;
  localparam int RS = 8;
  localparam int RR = 4;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst, edit, nxt, up, dn, rd_done, wr_ack;
  logic modify, load, wr_req;
  logic [2:0] up_sel, down_sel;
  logic [1:0] sel;
  logic [10:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  rtc_edit_sequencer #(.REPEAT_START(RS), .REPEAT_RATE(RR), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_btn_edit(edit), .i_btn_next(nxt), .i_btn_up(up),
    .i_btn_down(dn), .i_rd_done(rd_done), .i_wr_ack(wr_ack), .o_modify(modify),
    .o_up_sel(up_sel), .o_down_sel(down_sel), .o_load(load), .o_wr_req(wr_req), .o_sel(sel)
  );
  always #5 clk = ~clk;
  int mode = 0;
  int m_sel = 0;
  int cyc = 0;
  int last_act = 0;
  int press_btn = -1;
  int press_cyc = 0;
  bit fresh = 1'b1;
  bit [3:0] prev = 4'd0;
  always @(posedge clk) begin
    bit [3:0] cur, ed;
    bit e_up, e_dn, e_load, single, fire;
    int which, k;
    cyc++;
    e_up = 0;
    e_dn = 0;
    e_load = 0;
    if (rst) begin
      mode = 0;
      m_sel = 0;
      prev = 0;
      fresh = 1;
      press_btn = -1;
    end else begin
      cur = {dn, up, nxt, edit};
      ed = fresh ? 4'd0 : (cur & ~prev);
      prev = cur;
      fresh = 0;
      e_load = (mode == 0) && rd_done;
      single = up ^ dn;
      which = up ? 0 : 1;
      if (mode == 0) begin
        if (ed[0]) begin
          mode = 1;
          m_sel = 0;
          last_act = cyc;
          press_btn = -1;
        end
      end else if (mode == 1) begin
        if (single && ed[which + 2]) begin
          press_btn = which;
          press_cyc = cyc;
        end else if (!single || press_btn != which)
          press_btn = -1;
        k = cyc - press_cyc;
        fire = press_btn >= 0 && (k == 0 || (k >= RS && (k - RS) % RR == 0));
        if (ed[0]) begin
          mode = 2;
          press_btn = -1;
        end else if (cyc - last_act == TO) begin
          mode = 0;
          press_btn = -1;
        end else if (ed[1])
          m_sel = (m_sel == 2) ? 0 : m_sel + 1;
        else if (fire) begin
          e_up = (which == 0);
          e_dn = (which == 1);
        end
        if (ed != 0 || e_up || e_dn) last_act = cyc;
      end else if (wr_ack)
        mode = 0;
    end
    exp_q.push_back({mode != 0, e_up ? 3'(1 << m_sel) : 3'd0, e_dn ? 3'(1 << m_sel) : 3'd0,
                     e_load, mode == 2, 2'(m_sel)});
  end
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      logic [10:0] e, a;
      e = exp_q.pop_front();
      a = {modify, up_sel, down_sel, load, wr_req, sel};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got mod=%b up=%b dn=%b load=%b wr=%b sel=%0d want mod=%b up=%b dn=%b load=%b wr=%b sel=%0d",
                 $time, a[10], a[9:7], a[6:4], a[3], a[2], a[1:0], e[10], e[9:7], e[6:4], e[3], e[2], e[1:0]);
      end
    end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic e_mod, logic e_wr);
    checks++;
    if (modify !== e_mod || wr_req !== e_wr || load !== 1'b0 || up_sel !== 3'd0 || down_sel !== 3'd0) begin
      failures++;
      $display("FAIL %s t=%0t mod=%b wr=%b load=%b up=%b dn=%b", tag, $time, modify, wr_req, load, up_sel, down_sel);
    end
  endtask
  initial begin
    {edit, nxt, up, dn, rd_done, wr_ack} = '0;
    rst = 1'b1;
    tick(3);
    chk("reset", 1'b0, 1'b0);
    rst = 1'b0;
    tick(7);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick(3);
    edit = 1'b1; tick(); edit = 1'b0; tick(2);
    up = 1'b1; tick(); up = 1'b0; tick(2);
    nxt = 1'b1; tick(); nxt = 1'b0; tick();
    nxt = 1'b1; tick(); nxt = 1'b0; tick();
    dn = 1'b1; tick(); dn = 1'b0; tick(2);
    nxt = 1'b1; tick(); nxt = 1'b0; tick();
    up = 1'b1; tick(21); up = 1'b0; tick(5);
    nxt = 1'b1; up = 1'b1; tick(); nxt = 1'b0; up = 1'b0; tick(2);
    up = 1'b1; dn = 1'b1; tick(15); up = 1'b0; dn = 1'b0; tick(2);
    dn = 1'b1; tick(13); dn = 1'b0; tick(2);
    rd_done = 1'b1; tick(); rd_done = 1'b0; tick(60);
    chk("timeout", 1'b0, 1'b0);
    rd_done = 1'b1; tick(); rd_done = 1'b0; tick(2);
    edit = 1'b1; tick(); edit = 1'b0; tick(3);
    edit = 1'b1; tick(); edit = 1'b0; tick(5);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0; tick(3);
    edit = 1'b1; tick(); edit = 1'b0; tick(2);
    edit = 1'b1; tick(); edit = 1'b0; tick(2);
    rst = 1'b1; tick(); rst = 1'b0; tick(3);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0; tick(2);
    edit = 1'b1; rst = 1'b1; tick(2); rst = 1'b0; tick(3); edit = 1'b0; tick(3);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) edit = ~edit;
      if ($urandom_range(0, 15) == 0) nxt = ~nxt;
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 19) == 0) dn = ~dn;
      rd_done = $urandom_range(0, 7) == 0;
      wr_ack = $urandom_range(0, 5) == 0;
      rst = $urandom_range(0, 599) == 0;
      if ($urandom_range(0, 249) == 0) begin
        {edit, nxt, up, dn, rst} = '0;
        tick(70);
      end
      tick();
    end
    {edit, nxt, up, dn, rd_done, wr_ack, rst} = '0;
    tick(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
